// File: rtl/reel_pkg.sv
// Shared types and constants for the reel quadrature decoder.
package reel_pkg;

    localparam int REEL_W = 14;
    localparam int ACC_W  = 16;

    typedef enum logic [1:0] {
        IDLE,
        TURNING,
        FAULT
    } state_t;

    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_FWD,
        STEP_REV,
        STEP_ERR
    } step_t;

    // Forward order is 00 -> 01 -> 11 -> 10 -> 00; a two-bit change is illegal.
    function automatic step_t decode_step(input logic [1:0] prev, input logic [1:0] cur);
        step_t s;
        s = STEP_NONE;
        if (prev != cur) begin
            case ({prev, cur})
                4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: s = STEP_FWD;
                4'b01_00, 4'b11_01, 4'b10_11, 4'b00_10: s = STEP_REV;
                default:                                s = STEP_ERR;
            endcase
        end
        return s;
    endfunction

endpackage

// File: rtl/reel_quadrature_decoder_quad_step_decode.sv
// Synchronizes the encoder pins, optionally debounces them (REEL_DEBOUNCE_EN),
// and emits one quadrature step code per clk from the current vs previous AB.
module quad_step_decode
    import reel_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  i_enc_a,
    input  logic  i_enc_b,
    output step_t o_step
);

    logic [SYNC_STAGES-1:0] r_sync_a;
    logic [SYNC_STAGES-1:0] r_sync_b;
    logic [1:0]             w_synced;
    logic [1:0]             w_ab;
    logic [1:0]             r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync_a <= '0;
            r_sync_b <= '0;
        end else begin
            r_sync_a <= {r_sync_a[SYNC_STAGES-2:0], i_enc_a};
            r_sync_b <= {r_sync_b[SYNC_STAGES-2:0], i_enc_b};
        end
    end

    assign w_synced = {r_sync_a[SYNC_STAGES-1], r_sync_b[SYNC_STAGES-1]};

`ifdef REEL_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]       r_filt;
    logic [CNT_W-1:0] r_cnt [2];

    // A channel flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_filt <= '0;
            for (int unsigned i = 0; i < 2; i++) r_cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                if (w_synced[i] != r_filt[i]) begin
                    if (r_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                        r_filt[i] <= w_synced[i];
                        r_cnt[i]  <= '0;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                    end
                end else begin
                    r_cnt[i] <= '0;
                end
            end
        end
    end

    assign w_ab = r_filt;
`else
    logic [31:0] w_unused_debounce;
    assign w_unused_debounce = DEBOUNCE_CYCLES;
    assign w_ab = w_synced;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_prev <= '0;
        else     r_prev <= w_ab;
    end

    assign o_step = decode_step(r_prev, w_ab);

endmodule

// File: rtl/reel_quadrature_decoder.sv
// Reel crank decoder: accumulates quadrature steps per game window, reports detents
// on frame_tick and tracks motion/fault. Optional input debounce: REEL_DEBOUNCE_EN.
module reel_quadrature_decoder
    import reel_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DETENT_SHIFT    = 2,
    parameter int FAULT_LIMIT     = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enc_a,
    input  logic              enc_b,
    input  logic              frame_tick,
    output logic [REEL_W-1:0] reel,
    output logic              reel_dir,
    output logic              reel_valid,
    output logic              fault
);

    localparam int ERR_W = $clog2(FAULT_LIMIT + 1);
    localparam logic signed [ACC_W-1:0] ACC_MAX   = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN   = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [ACC_W-1:0]        REEL_CLIP = ACC_W'((1 << REEL_W) - 1);

    step_t                    w_step;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [ACC_W-1:0]  w_delta;
    logic signed [ACC_W-1:0]  w_acc_step;
    logic [ERR_W-1:0]         r_err;
    logic [ACC_W-1:0]         w_shifted;
    logic [REEL_W-1:0]        w_mag;
    state_t                   r_state;
    state_t                   w_state_next;
    logic [REEL_W-1:0]        r_reel;
    logic                     r_reel_dir;
    logic                     r_reel_valid;

    quad_step_decode #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_step (
        .clk     (clk),
        .rst     (rst),
        .i_enc_a (enc_a),
        .i_enc_b (enc_b),
        .o_step  (w_step)
    );

    always_comb begin
        w_delta    = '0;
        w_acc_step = r_acc;
        case (w_step)
            STEP_FWD: w_delta = ACC_W'(1);
            STEP_REV: w_delta = '1;
            default:  w_delta = '0;
        endcase
        if (!((w_step == STEP_FWD && r_acc == ACC_MAX) ||
              (w_step == STEP_REV && r_acc == ACC_MIN))) begin
            w_acc_step = r_acc + w_delta;
        end
    end

    // The tick cycle's own step seeds the new window instead of the closing one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_err <= '0;
        end else if (frame_tick) begin
            r_acc <= w_delta;
            r_err <= (w_step == STEP_ERR) ? ERR_W'(1) : '0;
        end else begin
            r_acc <= w_acc_step;
            if (w_step == STEP_ERR && r_err < ERR_W'(FAULT_LIMIT)) begin
                r_err <= r_err + ERR_W'(1);
            end
        end
    end

    always_comb begin
        w_shifted = $unsigned(r_acc) >> DETENT_SHIFT;
        w_mag     = w_shifted[REEL_W-1:0];
        if (w_shifted > REEL_CLIP) w_mag = '1;
    end

    always_comb begin
        w_state_next = r_state;
        if (frame_tick) begin
            if (r_err >= ERR_W'(FAULT_LIMIT)) begin
                w_state_next = FAULT;
            end else begin
                case (r_state)
                    IDLE:    if (r_acc != '0) w_state_next = TURNING;
                    TURNING: if (r_acc == '0) w_state_next = IDLE;
                    FAULT:   if (r_err == '0) w_state_next = (r_acc == '0) ? IDLE : TURNING;
                    default: w_state_next = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_reel       <= '0;
            r_reel_dir   <= 1'b0;
            r_reel_valid <= 1'b0;
        end else begin
            r_reel_valid <= frame_tick;
            if (frame_tick) begin
                if (w_state_next == FAULT) begin
                    r_reel     <= '0;
                    r_reel_dir <= 1'b0;
                end else if (r_acc[ACC_W-1]) begin
                    r_reel     <= '0;
                    r_reel_dir <= 1'b1;
                end else begin
                    r_reel     <= w_mag;
                    r_reel_dir <= 1'b0;
                end
            end
        end
    end

    assign reel       = r_reel;
    assign reel_dir   = r_reel_dir;
    assign reel_valid = r_reel_valid;
    assign fault      = (r_state == FAULT);

endmodule

// File: tb/tb_reel_quadrature_decoder.sv
// Self-checking bench: window table, hand-written tick/reset corners, random windows vs model.
`timescale 1ns/1ps
module tb_reel_quadrature_decoder;
    import reel_pkg::*;

    localparam int SYNC  = 2;
    localparam int SHIFT = 2;
    localparam int LIMIT = 4;
    localparam int DEB   = 16;
`ifdef REEL_DEBOUNCE_EN
    localparam int LAT     = SYNC + DEB;
    localparam int SPACING = 30;
`else
    localparam int LAT     = SYNC;
    localparam int SPACING = 10;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        enc_a, enc_b, frame_tick;
    logic [13:0] reel;
    logic        reel_dir, reel_valid, fault;

    reel_quadrature_decoder #(
        .SYNC_STAGES     (SYNC),
        .DETENT_SHIFT    (SHIFT),
        .FAULT_LIMIT     (LIMIT),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enc_a      (enc_a),
        .enc_b      (enc_b),
        .frame_tick (frame_tick),
        .reel       (reel),
        .reel_dir   (reel_dir),
        .reel_valid (reel_valid),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: encoder phase index, window totals, and 0=idle 1=moving 2=faulted.
    int pos = 0;
    int m_acc = 0, m_err = 0, m_state = 0;
    int e_reel, e_dir, e_flt, e_st;

    typedef struct {
        int fwd; int rev; int err;
        int reel; int dir; int flt; int st;
    } vec_t;
    vec_t vecs[16];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [1:0] phase_ab(input int p);
        case (p & 3)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    function automatic int st_code(input int s);
        state_t t;
        t = (s == 0) ? IDLE : (s == 1) ? TURNING : FAULT;
        return int'(t);
    endfunction

    // kind: 0 forward quarter-step, 1 reverse, 2 illegal jump
    task automatic move(input int kind);
        if (kind == 0) begin pos += 1; if (m_acc < 32767) m_acc++; end
        else if (kind == 1) begin pos -= 1; if (m_acc > -32768) m_acc--; end
        else begin pos += 2; if (m_err < LIMIT) m_err++; end
        {enc_a, enc_b} = phase_ab(pos);
        repeat (SPACING) @(negedge clk);
    endtask

    task automatic settle();
        repeat (LAT + 3) @(negedge clk);
    endtask

    task automatic model_tick();
        int ns;
        if (m_err >= LIMIT || (m_state == 2 && m_err != 0)) ns = 2;
        else ns = (m_acc != 0) ? 1 : 0;
        e_flt = (ns == 2) ? 1 : 0;
        e_st  = ns;
        if (ns == 2)        begin e_reel = 0; e_dir = 0; end
        else if (m_acc < 0) begin e_reel = 0; e_dir = 1; end
        else begin
            e_reel = m_acc / (1 << SHIFT);
            if (e_reel > 16383) e_reel = 16383;
            e_dir = 0;
        end
        m_acc = 0; m_err = 0; m_state = ns;
    endtask

    task automatic check_out(input string tag, input int er, input int ed, input int ef, input int es);
        check({tag, " valid"}, int'(reel_valid), 1);
        check({tag, " reel"},  int'(reel), er);
        check({tag, " dir"},   int'(reel_dir), ed);
        check({tag, " fault"}, int'(fault), ef);
        check({tag, " state"}, int'(dut.r_state), st_code(es));
    endtask

    task automatic do_tick(input string tag, input int er, input int ed, input int ef, input int es);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        check_out(tag, er, ed, ef, es);
        @(negedge clk);
        check({tag, " valid drop"}, int'(reel_valid), 0);
    endtask

    task automatic tick_model(input string tag);
        model_tick();
        do_tick(tag, e_reel, e_dir, e_flt, e_st);
    endtask

    initial begin
        vecs[0]  = '{0, 0, 0, 0, 0, 0, 0};
        vecs[1]  = '{40, 0, 0, 10, 0, 0, 1};
        vecs[2]  = '{0, 0, 0, 0, 0, 0, 0};
        vecs[3]  = '{0, 12, 0, 0, 1, 0, 1};
        vecs[4]  = '{8, 4, 0, 1, 0, 0, 1};
        vecs[5]  = '{0, 0, 5, 0, 0, 1, 2};
        vecs[6]  = '{8, 0, 0, 2, 0, 0, 1};
        vecs[7]  = '{3, 0, 0, 0, 0, 0, 1};
        vecs[8]  = '{0, 0, 2, 0, 0, 0, 0};
        vecs[9]  = '{0, 0, 4, 0, 0, 1, 2};
        vecs[10] = '{4, 0, 1, 0, 0, 1, 2};
        vecs[11] = '{0, 0, 0, 0, 0, 0, 0};
        vecs[12] = '{0, 5, 0, 0, 1, 0, 1};
        vecs[13] = '{0, 0, 3, 0, 0, 0, 0};
        vecs[14] = '{0, 0, 4, 0, 0, 1, 2};
        vecs[15] = '{16, 0, 0, 4, 0, 0, 1};

        rst = 1'b1; enc_a = 1'b0; enc_b = 1'b0; frame_tick = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset valid", int'(reel_valid), 0);
        check("reset reel",  int'(reel), 0);
        check("reset dir",   int'(reel_dir), 0);
        check("reset fault", int'(fault), 0);
        check("reset state", int'(dut.r_state), st_code(0));

        for (int v = 0; v < 16; v++) begin
            for (int k = 0; k < vecs[v].fwd; k++) move(0);
            for (int k = 0; k < vecs[v].rev; k++) move(1);
            for (int k = 0; k < vecs[v].err; k++) move(2);
            settle();
            model_tick();
            do_tick($sformatf("vec%0d", v), vecs[v].reel, vecs[v].dir, vecs[v].flt, vecs[v].st);
        end

        // Step arriving in the tick cycle belongs to the next window.
        tick_model("pre-align");
        for (int k = 0; k < 3; k++) move(0);
        settle();
        pos += 1;
        {enc_a, enc_b} = phase_ab(pos);
        repeat (LAT) @(negedge clk);
        tick_model("align old");
        m_acc += 1;
        repeat (SPACING) @(negedge clk);
        for (int k = 0; k < 3; k++) move(0);
        settle();
        tick_model("align new");
        tick_model("align empty");

        // Back-to-back ticks: the second window is empty.
        for (int k = 0; k < 8; k++) move(0);
        settle();
        model_tick();
        frame_tick = 1'b1;
        @(negedge clk);
        check_out("b2b first", e_reel, e_dir, e_flt, e_st);
        model_tick();
        @(negedge clk);
        frame_tick = 1'b0;
        check_out("b2b second", e_reel, e_dir, e_flt, e_st);
        @(negedge clk);
        check("b2b valid drop", int'(reel_valid), 0);

        // Reset in mid-window discards the partial count.
        for (int k = 0; k < 6 || (pos & 3) != 0; k++) move(0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst reel",  int'(reel), 0);
        check("midrst valid", int'(reel_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        m_acc = 0; m_err = 0; m_state = 0;
        settle();
        tick_model("post-reset");

`ifdef REEL_DEBOUNCE_EN
        // Short glitches must be filtered away entirely.
        enc_a = ~enc_a;
        repeat (10) @(negedge clk);
        enc_a = ~enc_a;
        settle();
        for (int k = 0; k < 5; k++) begin
            {enc_a, enc_b} = ~{enc_a, enc_b};
            repeat (10) @(negedge clk);
            {enc_a, enc_b} = ~{enc_a, enc_b};
            repeat (SPACING) @(negedge clk);
        end
        settle();
        tick_model("glitch");
        for (int k = 0; k < 40; k++) move(0);
        settle();
        tick_model("deb 40fwd");
`endif

        for (int w = 0; w < 20; w++) begin
            int n;
            int bias;
            n = $urandom_range(0, 30);
            bias = $urandom_range(0, 2);
            for (int k = 0; k < n; k++) begin
                int r;
                r = $urandom_range(0, 19);
                if (r == 19)                        move(2);
                else if (r < (bias == 0 ? 6 : 13))  move(1);
                else                                move(0);
            end
            settle();
            tick_model($sformatf("rand%0d", w));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
